// File: rtl/calc_pkg.sv
// Shared key codes, operator encoding, controller states and sizing helpers for the
// calculator entry controller.
package calc_pkg;

    localparam int unsigned KEY_W           = 5;
    localparam int unsigned CALC_MAX_DIGITS = 8;

    localparam logic [KEY_W-1:0] KEY_ADD       = 5'd10;
    localparam logic [KEY_W-1:0] KEY_SUB       = 5'd11;
    localparam logic [KEY_W-1:0] KEY_MUL       = 5'd12;
    localparam logic [KEY_W-1:0] KEY_DIV       = 5'd13;
    localparam logic [KEY_W-1:0] KEY_ENTER     = 5'd14;
    localparam logic [KEY_W-1:0] KEY_CLEAR     = 5'd15;
    localparam logic [KEY_W-1:0] KEY_BACKSPACE = 5'd16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } calc_state_e;

    // Counter width able to hold 0..max_digits inclusive.
    function automatic int unsigned digit_cnt_w(input int unsigned max_digits);
        return (max_digits < 1) ? 1 : $clog2(max_digits + 1);
    endfunction

    localparam int unsigned DIGIT_CNT_W = digit_cnt_w(CALC_MAX_DIGITS);

endpackage

// File: rtl/key_rise_det.sv
// Turns a held, debounced key level into a single accept pulse on its first cycle.
module key_rise_det
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    output logic             accept_c,
    output logic [KEY_W-1:0] key_c
);

    logic key_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
        end
    end

    assign accept_c = key_valid & ~key_valid_q;
    assign key_c    = key_code;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU sequencer: builds decimal operands, issues one ALU request, holds the result.
// Optional BACKSPACE editing is built when CALC_BACKSPACE_EN is defined.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_DIGITS = CALC_MAX_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic             alu_req,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_ack,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] display,
    output logic             err,
    output logic             busy
);

    localparam int unsigned   DW      = digit_cnt_w(MAX_DIGITS);
    localparam logic [DW-1:0] DIG_MAX = DW'(MAX_DIGITS);

    logic             key_acc_c;
    logic [KEY_W-1:0] key_c;

    key_rise_det u_key_rise_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .accept_c (key_acc_c),
        .key_c    (key_c)
    );

    calc_state_e      state, state_d;
    alu_op_e          op, op_d, alu_op_q, alu_op_d;
    logic [WIDTH-1:0] acc_a, acc_a_d, acc_b, acc_b_d;
    logic [WIDTH-1:0] display_d, alu_a_d, alu_b_d;
    logic [DW-1:0]    digits_a, digits_a_d, digits_b, digits_b_d;
    logic             alu_req_d, err_d, busy_d, clr_pend, clr_pend_d;

    logic             is_digit, is_oper, is_enter, is_clear;
    alu_op_e          key_op;
    logic [WIDTH-1:0] digit_val, acc_a_dig, acc_b_dig;
    logic             clear_all;

    // Key classification and the x10 + d accumulate paths.
    always_comb begin
        is_digit  = key_acc_c && (key_c < 5'd10);
        is_oper   = key_acc_c && (key_c >= KEY_ADD) && (key_c <= KEY_DIV);
        is_enter  = key_acc_c && (key_c == KEY_ENTER);
        is_clear  = key_acc_c && (key_c == KEY_CLEAR);
        key_op    = alu_op_e'(2'(key_c - KEY_ADD));
        digit_val = WIDTH'(key_c[3:0]);
        acc_a_dig = (acc_a << 3) + (acc_a << 1) + digit_val;
        acc_b_dig = (acc_b << 3) + (acc_b << 1) + digit_val;
    end

`ifdef CALC_BACKSPACE_EN
    logic             is_bs;
    logic [WIDTH-1:0] acc_a_div, acc_b_div;

    always_comb begin
        is_bs     = key_acc_c && (key_c == KEY_BACKSPACE);
        acc_a_div = acc_a / WIDTH'(10);
        acc_b_div = acc_b / WIDTH'(10);
    end
`endif

    always_comb begin
        state_d    = state;
        op_d       = op;
        acc_a_d    = acc_a;
        acc_b_d    = acc_b;
        digits_a_d = digits_a;
        digits_b_d = digits_b;
        display_d  = display;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        alu_op_d   = alu_op_q;
        alu_req_d  = alu_req;
        err_d      = err;
        busy_d     = busy;
        clr_pend_d = clr_pend;
        clear_all  = 1'b0;

        case (state)
            S_A: begin
                if (is_digit) begin
                    if (digits_a < DIG_MAX) begin
                        acc_a_d    = acc_a_dig;
                        digits_a_d = digits_a + DW'(1);
                        display_d  = acc_a_dig;
                    end
                end else if (is_oper) begin
                    op_d       = key_op;
                    acc_b_d    = '0;
                    digits_b_d = '0;
                    state_d    = S_B;
                end
`ifdef CALC_BACKSPACE_EN
                else if (is_bs && (digits_a != '0)) begin
                    acc_a_d    = acc_a_div;
                    digits_a_d = digits_a - DW'(1);
                    display_d  = acc_a_div;
                end
`endif
            end
            S_B: begin
                if (is_digit) begin
                    if (digits_b < DIG_MAX) begin
                        acc_b_d    = acc_b_dig;
                        digits_b_d = digits_b + DW'(1);
                        display_d  = acc_b_dig;
                    end
                end else if (is_oper) begin
                    if (digits_b == '0) begin
                        op_d = key_op;
                    end
                end else if (is_enter) begin
                    if (digits_b != '0) begin
                        alu_a_d   = acc_a;
                        alu_b_d   = acc_b;
                        alu_op_d  = op;
                        alu_req_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = S_EXEC;
                    end
                end
`ifdef CALC_BACKSPACE_EN
                else if (is_bs && (digits_b != '0)) begin
                    acc_b_d    = acc_b_div;
                    digits_b_d = digits_b - DW'(1);
                    display_d  = (digits_b == DW'(1)) ? acc_a : acc_b_div;
                end
`endif
            end
            S_EXEC: begin
                // A CLEAR here is deferred until the ALU handshake completes.
                if (is_clear) begin
                    clr_pend_d = 1'b1;
                end
                if (alu_ack) begin
                    alu_req_d = 1'b0;
                    busy_d    = 1'b0;
                    if (clr_pend || is_clear) begin
                        clear_all = 1'b1;
                    end else if (alu_err) begin
                        err_d     = 1'b1;
                        display_d = '0;
                        state_d   = S_ERR;
                    end else begin
                        display_d = alu_result;
                        state_d   = S_RES;
                    end
                end
            end
            S_RES: begin
                if (is_digit) begin
                    acc_a_d    = digit_val;
                    digits_a_d = DW'(1);
                    display_d  = digit_val;
                    state_d    = S_A;
                end else if (is_oper) begin
                    // Chain: the shown result becomes a sealed operand A.
                    acc_a_d    = display;
                    digits_a_d = DIG_MAX;
                    op_d       = key_op;
                    acc_b_d    = '0;
                    digits_b_d = '0;
                    state_d    = S_B;
                end
            end
            S_ERR: begin
            end
            default: begin
                state_d = S_A;
            end
        endcase

        if ((is_clear && (state != S_EXEC)) || clear_all) begin
            state_d    = S_A;
            op_d       = OP_ADD;
            acc_a_d    = '0;
            acc_b_d    = '0;
            digits_a_d = '0;
            digits_b_d = '0;
            display_d  = '0;
            alu_a_d    = '0;
            alu_b_d    = '0;
            alu_op_d   = OP_ADD;
            alu_req_d  = 1'b0;
            err_d      = 1'b0;
            busy_d     = 1'b0;
            clr_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            op       <= OP_ADD;
            acc_a    <= '0;
            acc_b    <= '0;
            digits_a <= '0;
            digits_b <= '0;
            display  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op_q <= OP_ADD;
            alu_req  <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            state    <= state_d;
            op       <= op_d;
            acc_a    <= acc_a_d;
            acc_b    <= acc_b_d;
            digits_a <= digits_a_d;
            digits_b <= digits_b_d;
            display  <= display_d;
            alu_a    <= alu_a_d;
            alu_b    <= alu_b_d;
            alu_op_q <= alu_op_d;
            alu_req  <= alu_req_d;
            err      <= err_d;
            busy     <= busy_d;
            clr_pend <= clr_pend_d;
        end
    end

    assign alu_op = alu_op_q;

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Sequences operand entry and operation dispatch for the calculator datapath.
- Converts key presses into decimal operands A and B (acc = 10*acc + digit) and latches an operator.
- Issues one request/acknowledge transaction to the arithmetic unit, then holds the result or error for display.
- Sits between the keypad decoder and the ALU/display path.

Parameters:
- WIDTH, 32, operand, result and display width in bits.
- MAX_DIGITS, 8, maximum decimal digits per operand; 10^MAX_DIGITS - 1 must fit in WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  level signal, high while a key is held; already debounced.
- key_code  in  5  key id: 0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 ENTER, 15 CLEAR, 16 BACKSPACE; others ignored.
- alu_req  out  1  request to the ALU.
- alu_op  out  2  operator: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- alu_a  out  WIDTH  operand A.
- alu_b  out  WIDTH  operand B.
- alu_ack  in  1  one-cycle completion strobe from the ALU.
- alu_result  in  WIDTH  ALU result; valid with alu_ack.
- alu_err  in  1  ALU error (divide by zero, overflow); valid with alu_ack.
- display  out  WIDTH  value to show.
- err  out  1  high in the error state.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to S_A.
  - acc_a, acc_b, digit counters, op, display and alu_a/alu_b are 0.
  - alu_req, err and busy are 0.
  - key_valid_q is 0.
- Key acceptance:
  - A key is accepted at a posedge where key_valid=1 and key_valid_q=0.
  - Holding a key produces exactly one accept.
  - All outputs are registered and change on the accepting edge.
- S_A:
  - Digit d: if digits_a < MAX_DIGITS, acc_a = 10*acc_a + d and digits_a increments; otherwise the digit is ignored (no wrap).
  - display = acc_a.
  - Operator: op is latched, acc_b and digits_b are cleared, go to S_B. With digits_a=0, A=0 is used.
  - ENTER is ignored.
- S_B:
  - Digits are handled as in S_A, into acc_b; display = acc_b once digits_b > 0, otherwise display stays acc_a.
  - Operator with digits_b=0 replaces op.
  - Operator with digits_b>0 is ignored.
  - ENTER with digits_b=0 is ignored.
  - ENTER with digits_b>0: drive alu_a=acc_a, alu_b=acc_b, alu_op=op, set alu_req=1 and busy=1, go to S_EXEC.
- S_EXEC:
  - alu_req, alu_a, alu_b and alu_op stay stable until the alu_ack edge; alu_req drops on that same edge.
  - alu_ack with alu_err=0: display = alu_result, go to S_RES.
  - alu_ack with alu_err=1: err=1, display=0, go to S_ERR.
  - busy clears together with alu_req.
  - Digit, operator and ENTER keys are dropped.
  - CLEAR sets a pending flag; the handshake still completes, and on ack the block applies the full clear instead of the result.
  - alu_ack outside S_EXEC is ignored.
- S_RES:
  - Digit d: acc_a=d, digits_a=1, go to S_A.
  - Operator: acc_a=result, digits_a=MAX_DIGITS (so no appends), latch op, go to S_B (chaining).
  - ENTER is ignored.
- S_ERR: only CLEAR exits; all other keys are ignored.
- CLEAR:
  - Outside S_EXEC, CLEAR returns every register to its reset value in one cycle.
  - CLEAR overrides any other condition in the same cycle.

Optional Feature:
- Macro: CALC_BACKSPACE_EN.
- Defined: BACKSPACE in S_A or S_B performs acc = acc/10 and digits = digits-1 when digits > 0, else no-op. In S_B with digits_b dropping to 0, display reverts to acc_a. BACKSPACE is ignored in other states. After operator chaining (digits_a=MAX_DIGITS) it still divides.
- Undefined: code 16 is treated as an unknown code and ignored; no divider logic is built.

Decomposition:
- Package calc_pkg:
  - key code localparams (KEY_ADD..KEY_BACKSPACE);
  - the op encoding;
  - the state enum (S_A, S_B, S_EXEC, S_RES, S_ERR);
  - a MAX_DIGITS-based digit counter width constant.
- Sub-module key_rise_det: registers key_valid and outputs a one-cycle accept pulse plus the captured key_code.
- The accumulate (x10 + d) logic stays inline.

Test Plan:
- Enter 1,2,ADD,3,4,ENTER with ALU acking 2 cycles later with 46 → display 1,12,12,3,34; alu_req for 3 cycles with a=12, b=34, op=0; display=46; state S_RES.
- Nine digits 9 in S_A with MAX_DIGITS=8 → acc_a = 99999999; the 9th press is ignored.
- Enter 5,DIV,0,ENTER; ack with alu_err=1 → err=1, display=0; digit 7 is ignored; CLEAR → err=0, display=0, state S_A.
- CLEAR pressed during S_EXEC, ack 3 cycles later with result 8 → alu_req stays high until ack; afterwards all registers are 0, display=0.
- Result 46 in S_RES, press MUL,2,ENTER → alu_a=46, alu_b=2, op=2; holding key_valid high 10 cycles on a digit → a single accept.
- With CALC_BACKSPACE_EN: 1,2,3,BACKSPACE → display 12; BACKSPACE ×3 → display 0 and digits=0; async rst_n pulse mid-entry → all outputs 0 immediately.
